div_dispatch: RTL
=================

DIV_DISPATCH -- requirements
Module: div_dispatch

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, request-buffer depth in entries, power of two, 2..8.
REQ-002 SHALL have parameter RR_START, default 0, core index of the first round-robin search after reset, 0..3.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_dividend  in  6  dividend operand.
REQ-007 SHALL have port req_divisor  in  4  divisor operand.
REQ-008 SHALL have port req_ready  out  1  buffer can accept a request.
REQ-009 SHALL have port core_full  in  4  per-core instruction-FIFO full flags of the multicore divider.
REQ-010 SHALL have port instruction  out  12  packed instruction to the divider: [11:10] core id, [9:4] dividend, [3:0] divisor.
REQ-011 SHALL have port wr_en  out  1  one-cycle write strobe qualifying instruction.
REQ-012 SHALL have port busy  out  1  buffer non-empty or FSM not IDLE.
REQ-013 SHALL have port err_div0  out  1  sticky divide-by-zero flag.
REQ-014 SHALL have port issued_count  out  8  count of issued instructions, wraps 255->0.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready = buffer not full.
REQ-016 SHALL store requests in a BUF_DEPTH FIFO, preserving order; simultaneous push and pop when full SHALL NOT be permitted (req_ready low when full).
REQ-017 SHALL implement FSM states IDLE, SELECT, ISSUE, STALL.
REQ-018 IDLE->SELECT when buffer non-empty; otherwise stay IDLE.
REQ-019 SELECT: search cores starting at rr_ptr, ascending mod 4, for the first with core_full=0; found -> latch target, go ISSUE; none -> STALL.
REQ-020 STALL: re-evaluate each cycle as in SELECT; leave when any core_full bit clears.
REQ-021 ISSUE: instruction = {target, dividend, divisor} of buffer head; wr_en = 1 for exactly one cycle only if core_full[target]=0, then pop head, rr_ptr = target+1 mod 4, issued_count +1, go SELECT if buffer still non-empty, else IDLE.
REQ-022 ISSUE with core_full[target]=1: wr_en stays 0, no pop, go SELECT.
REQ-023 Latency: request accepted at edge N into an empty buffer -> wr_en high in the cycle after edge N+2; sustained throughput one instruction per 2 cycles.
REQ-024 instruction SHALL hold its last issued value when wr_en=0.

Reset
REQ-025 rst low SHALL immediately clear buffer, FSM=IDLE, rr_ptr=RR_START, instruction=0, wr_en=0, req_ready=0 during reset, busy=0, err_div0=0, issued_count=0.
REQ-026 rst asserted mid-ISSUE SHALL suppress wr_en in that cycle; buffered requests are discarded.
REQ-027 req_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-028 Macro DIV_DISPATCH_ZERO_FILTER_EN defined: a request with divisor 0 at buffer head SHALL be popped in SELECT without issue, set err_div0, and not increment issued_count.
REQ-029 Macro undefined: divisor-0 requests SHALL be issued normally and err_div0 SHALL be constant 0.

Verification
REQ-030 Reset then one request (dividend 45, divisor 3), core_full=0000 -> wr_en one cycle, instruction=12'b00_101101_0011, issued_count=1.
REQ-031 Four back-to-back requests, core_full=0000 -> core ids 0,1,2,3 in order, wr_en every 2nd cycle, issued_count=4.
REQ-032 core_full=0010, two requests -> core ids 0 then 2 (core 1 skipped).
REQ-033 core_full=1111 with buffered request -> FSM STALL, no wr_en, req_ready low once buffer full; clear core_full[3] -> issue to core 3.
REQ-034 With DIV_DISPATCH_ZERO_FILTER_EN: request divisor 0 then divisor 5 -> only divisor-5 instruction issued, err_div0=1; without macro both issued, err_div0=0.
REQ-035 Assert rst during ISSUE cycle -> wr_en 0, all outputs at reset values, busy=0.

Source files
------------

// File: rtl/div_dispatch.sv
// Request buffer plus round-robin dispatcher feeding a four-core divider.
// Optional feature: define DIV_DISPATCH_ZERO_FILTER_EN to drop divide-by-zero requests.
module div_dispatch #(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned RR_START  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  req_dividend,
    input  logic [3:0]  req_divisor,
    output logic        req_ready,
    input  logic [3:0]  core_full,
    output logic [11:0] instruction,
    output logic        wr_en,
    output logic        busy,
    output logic        err_div0,
    output logic [7:0]  issued_count
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StSelect, StIssue, StStall} state_e;

    state_e          state_q, state_d;
    logic [9:0]      mem_q [BUF_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d, target_q, target_d, pick, idx;
    logic [11:0]     instr_q;
    logic [7:0]      count_q;
    logic [9:0]      head;
    logic            found, push, pop, leave, zero_head, empty, err_q, err_set, wr_en_c;

    assign head      = mem_q[rd_ptr_q];
    assign empty     = (cnt_q == '0);
    // Ready is forced low while reset is held so nothing is accepted into a cleared buffer.
    assign req_ready = rst & (cnt_q != (PtrW+1)'(BUF_DEPTH));
    assign push      = req_valid & req_ready;

`ifdef DIV_DISPATCH_ZERO_FILTER_EN
    assign zero_head = (head[3:0] == 4'd0);
`else
    assign zero_head = 1'b0;
`endif

    // Lowest offset from rr_ptr_q wins, hence the descending scan.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr_q + 2'(i);
            if (!core_full[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rr_ptr_d = rr_ptr_q;
        pop      = 1'b0;
        wr_en_c  = 1'b0;
        leave    = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StSelect;
            end
            StSelect, StStall: begin
                if (empty) begin
                    state_d = StIdle;
                end else if (state_q == StSelect && zero_head) begin
                    pop     = 1'b1;
                    err_set = 1'b1;
                    leave   = 1'b1;
                end else if (found) begin
                    target_d = pick;
                    state_d  = StIssue;
                end else begin
                    state_d = StStall;
                end
            end
            StIssue: begin
                if (!core_full[target_q]) begin
                    wr_en_c  = 1'b1;
                    pop      = 1'b1;
                    rr_ptr_d = target_q + 2'd1;
                    leave    = 1'b1;
                end else begin
                    state_d = StSelect;
                end
            end
            default: state_d = StIdle;
        endcase
        cnt_d = cnt_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
        // A same-cycle push keeps the pipeline in SELECT instead of bouncing through IDLE.
        if (leave) state_d = (cnt_d != '0) ? StSelect : StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            target_q <= 2'(RR_START);
            rr_ptr_q <= 2'(RR_START);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (wr_en_c) begin
                instr_q <= {target_q, head};
                count_q <= count_q + 8'd1;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_dividend, req_divisor};
    end

    assign wr_en        = wr_en_c;
    assign instruction  = wr_en_c ? {target_q, head} : instr_q;
    assign busy         = !empty || (state_q != StIdle);
    assign err_div0     = err_q;
    assign issued_count = count_q;

endmodule
